// File: rtl/alu_step_sequencer.sv
// rtl/alu_step_sequencer.sv - fetch/execute control step generator for the DataPath
// Walks T0..T6 once per instruction and drives the Moore control strobes for
// the current step. Fetch is T0..T2, and T1 stretches until memory data is
// ready. Execute decodes IR from T3 onward.
module alu_step_sequencer #(
   parameter int IR_WIDTH  = 32,
   parameter int OPCODE_W  = 5,
   parameter int REG_SEL_W = 4,
   parameter int COUNT_W   = 16
) (
   input  logic                      Clock,
   input  logic                      clear,
   input  logic                      run,
   input  logic                      mem_ready,
   input  logic [IR_WIDTH-1:0]       IR,
   output logic                      PCout,
   output logic                      IncPC,
   output logic                      MARin,
   output logic                      PCin,
   output logic                      Read,
   output logic                      MDRin,
   output logic                      MDRout,
   output logic                      IRin,
   output logic                      Yin,
   output logic                      Zin_low,
   output logic                      Zin_high,
   output logic                      Zlowout,
   output logic                      Zhighout,
   output logic                      HIin,
   output logic                      LOin,
   output logic [2**REG_SEL_W-1:0]   reg_out,
   output logic [2**REG_SEL_W-1:0]   reg_in,
   output logic [OPCODE_W-1:0]       alu_op,
   output logic                      busy,
   output logic                      done,
   output logic                      illegal,
   output logic [COUNT_W-1:0]        instr_count
);

   localparam int NUM_REGS = 2**REG_SEL_W;
   localparam int RA_MSB   = IR_WIDTH - OPCODE_W - 1;
   localparam int RB_MSB   = RA_MSB - REG_SEL_W;
   localparam int RC_MSB   = RB_MSB - REG_SEL_W;
   localparam int LOW_MSB  = RC_MSB - REG_SEL_W;

   typedef enum logic [2:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [COUNT_W-1:0]   r_count;

   logic [OPCODE_W-1:0]  w_opcode;
   logic [REG_SEL_W-1:0] w_ra;
   logic [REG_SEL_W-1:0] w_rb;
   logic [REG_SEL_W-1:0] w_rc;
   logic [NUM_REGS-1:0]  w_ra_hot;
   logic [NUM_REGS-1:0]  w_rb_hot;
   logic [NUM_REGS-1:0]  w_rc_hot;
   logic                 w_is_3reg;
   logic                 w_is_hilo;
   logic                 w_is_2reg;
   logic                 w_final;
   logic                 w_unused_ir_low;

   assign w_opcode = IR[IR_WIDTH-1 -: OPCODE_W];
   assign w_ra     = IR[RA_MSB -: REG_SEL_W];
   assign w_rb     = IR[RB_MSB -: REG_SEL_W];
   assign w_rc     = IR[RC_MSB -: REG_SEL_W];
   assign w_ra_hot = NUM_REGS'(1) << w_ra;
   assign w_rb_hot = NUM_REGS'(1) << w_rb;
   assign w_rc_hot = NUM_REGS'(1) << w_rc;

   // The immediate/low field below Rc carries nothing this sequencer needs.
   assign w_unused_ir_low = ^IR[LOW_MSB:0];

   assign w_is_3reg = (w_opcode >= OPCODE_W'(3)) && (w_opcode <= OPCODE_W'(10));
   assign w_is_hilo = (w_opcode == OPCODE_W'(15)) || (w_opcode == OPCODE_W'(16));
   assign w_is_2reg = (w_opcode == OPCODE_W'(17)) || (w_opcode == OPCODE_W'(18));

   // State register and completed-instruction counter.
   always_ff @(posedge Clock) begin
      if (clear) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_final) begin
            r_count <= r_count + COUNT_W'(1);
         end
      end
   end

   // Next-state and Moore strobe decode; clear blanks every output in its cycle.
   always_comb begin
      w_next      = r_state;
      w_final     = 1'b0;
      PCout       = 1'b0;
      IncPC       = 1'b0;
      MARin       = 1'b0;
      PCin        = 1'b0;
      Read        = 1'b0;
      MDRin       = 1'b0;
      MDRout      = 1'b0;
      IRin        = 1'b0;
      Yin         = 1'b0;
      Zin_low     = 1'b0;
      Zin_high    = 1'b0;
      Zlowout     = 1'b0;
      Zhighout    = 1'b0;
      HIin        = 1'b0;
      LOin        = 1'b0;
      reg_out     = '0;
      reg_in      = '0;
      alu_op      = '0;
      illegal     = 1'b0;
      busy        = (r_state != S_IDLE);
      instr_count = r_count;

      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_next = S_T0;
            end
         end
         S_T0: begin
            PCout   = 1'b1;
            MARin   = 1'b1;
            IncPC   = 1'b1;
            Zin_low = 1'b1;
            w_next  = S_T1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            if (mem_ready) begin
               w_next = S_T2;
            end
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
            w_next = S_T3;
         end
         S_T3: begin
            if (w_is_3reg || w_is_hilo) begin
               reg_out = w_rb_hot;
               Yin     = 1'b1;
               w_next  = S_T4;
            end else if (w_is_2reg) begin
               reg_out = w_rb_hot;
               alu_op  = w_opcode;
               Zin_low = 1'b1;
               w_next  = S_T4;
            end else begin
               illegal = 1'b1;
               w_next  = run ? S_T0 : S_IDLE;
            end
         end
         S_T4: begin
            if (w_is_3reg || w_is_hilo) begin
               reg_out  = w_rc_hot;
               alu_op   = w_opcode;
               Zin_low  = 1'b1;
               Zin_high = w_is_hilo;
               w_next   = S_T5;
            end else if (w_is_2reg) begin
               Zlowout = 1'b1;
               reg_in  = w_ra_hot;
               w_final = 1'b1;
               w_next  = run ? S_T0 : S_IDLE;
            end else begin
               // IR changed under us mid-execute; abandon without completing.
               w_next = S_IDLE;
            end
         end
         S_T5: begin
            if (w_is_3reg) begin
               Zlowout = 1'b1;
               reg_in  = w_ra_hot;
               w_final = 1'b1;
               w_next  = run ? S_T0 : S_IDLE;
            end else if (w_is_hilo) begin
               Zlowout = 1'b1;
               LOin    = 1'b1;
               w_next  = S_T6;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_T6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
            w_final  = 1'b1;
            w_next   = run ? S_T0 : S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase

      done = w_final;

      if (clear) begin
         PCout       = 1'b0;
         IncPC       = 1'b0;
         MARin       = 1'b0;
         PCin        = 1'b0;
         Read        = 1'b0;
         MDRin       = 1'b0;
         MDRout      = 1'b0;
         IRin        = 1'b0;
         Yin         = 1'b0;
         Zin_low     = 1'b0;
         Zin_high    = 1'b0;
         Zlowout     = 1'b0;
         Zhighout    = 1'b0;
         HIin        = 1'b0;
         LOin        = 1'b0;
         reg_out     = '0;
         reg_in      = '0;
         alu_op      = '0;
         illegal     = 1'b0;
         done        = 1'b0;
         busy        = 1'b0;
         instr_count = '0;
      end
   end

endmodule
